// File: rtl/fft_pkg.sv
`timescale 1ns/1ps
// Shared types and helpers for the FFT input framer and its downstream users.
package fft_pkg;

  localparam int SINK_WIDTH_DEF = 14;
  localparam int FFT_DEPTH_DEF  = 11;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    GAP
  } state_t;

  typedef struct packed {
    logic signed [SINK_WIDTH_DEF-1:0] Re;
    logic signed [SINK_WIDTH_DEF-1:0] Im;
  } sample_t;

  // Bit growth of the FFT core: one bit per radix-4 stage on top of the input width.
  function automatic int fft_width(input int sink_width, input int fft_depth);
    return sink_width + (fft_depth + 1) / 2;
  endfunction

  localparam int FFT_WIDTH = fft_width(SINK_WIDTH_DEF, FFT_DEPTH_DEF);

endpackage

// File: rtl/fft_framer_if.sv
`timescale 1ns/1ps
// Sample stream in and FFT sink stream out of the framer.
// master: the framer itself; slave: the surrounding logic that feeds and drains it.
interface fft_framer_if #(
  parameter int SINK_WIDTH = 14
);

  logic                         in_valid;
  logic                         in_ready;
  logic signed [SINK_WIDTH-1:0] in_Re;
  logic signed [SINK_WIDTH-1:0] in_Im;

  logic                         source_ready;
  logic                         source_valid;
  logic                         source_sop;
  logic                         source_eop;
  logic signed [SINK_WIDTH-1:0] source_Re;
  logic signed [SINK_WIDTH-1:0] source_Im;

  modport master (
    input  in_valid, in_Re, in_Im, source_ready,
    output in_ready, source_valid, source_sop, source_eop, source_Re, source_Im
  );

  modport slave (
    output in_valid, in_Re, in_Im, source_ready,
    input  in_ready, source_valid, source_sop, source_eop, source_Re, source_Im
  );

endinterface

// File: rtl/fft_framer_fifo.sv
`timescale 1ns/1ps
// First-word-fall-through FIFO; the head word is read straight out of registered storage,
// so a word written at one edge is on dout after that edge and not before.
module fft_framer_fifo #(
  parameter int WIDTH = 28,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             aclr_n,
  input  logic             wr,
  input  logic             rd,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_wr;
  logic             do_rd;

  // A write into a full FIFO is lost even when a read frees a slot in the same cycle.
  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  assign do_wr = wr && !full;
  assign do_rd = rd && !empty;
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_wr) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_rd) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fft_framer.sv
`timescale 1ns/1ps
// Packs a continuous complex sample stream into sop/eop-framed packets of 2**FFT_DEPTH
// samples for the FFT sink, with buffering, backpressure, inter-frame gaps and overflow flag.
module fft_framer #(
  parameter int FFT_DEPTH  = 11,
  parameter int SINK_WIDTH = 14,
  parameter int FIFO_DEPTH = 16,
  parameter int GAP_W      = 8,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             aclr_n,
  input  logic             enable,
  input  logic             oneshot,
  input  logic [GAP_W-1:0] gap,
  input  logic             err_clr,
  fft_framer_if.master     bus,
  output logic             busy,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             error
);

  import fft_pkg::*;

  localparam logic [FFT_DEPTH-1:0] LAST_IDX = '1;

  state_t                  state;
  state_t                  state_next;
  logic [FFT_DEPTH-1:0]    idx;
  logic [GAP_W-1:0]        gap_cnt;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    xfer;
  logic                    last;
  logic                    drop;
  logic [2*SINK_WIDTH-1:0] fifo_din;
  logic [2*SINK_WIDTH-1:0] fifo_dout;

  assign fifo_din = {bus.in_Re, bus.in_Im};

  fft_framer_fifo #(
    .WIDTH (2*SINK_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .aclr_n (aclr_n),
    .wr     (bus.in_valid),
    .rd     (xfer),
    .din    (fifo_din),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  // Framing flags are gated by valid so the sink never sees a stray sop while idle.
  assign bus.in_ready     = !fifo_full;
  assign bus.source_valid = (state == STREAM) && !fifo_empty;
  assign xfer             = bus.source_valid && bus.source_ready;
  assign last             = (idx == LAST_IDX);
  assign bus.source_sop   = bus.source_valid && (idx == '0);
  assign bus.source_eop   = bus.source_valid && last;
  assign bus.source_Re    = fifo_dout[2*SINK_WIDTH-1:SINK_WIDTH];
  assign bus.source_Im    = fifo_dout[SINK_WIDTH-1:0];
  assign drop             = bus.in_valid && fifo_full;
  assign busy             = (state != IDLE);

  // Enable and oneshot are only looked at on frame boundaries, so packets always complete.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (enable) state_next = STREAM;
      end
      STREAM: begin
        if (xfer && last) begin
          if (oneshot || !enable) state_next = IDLE;
          else if (gap == '0)     state_next = STREAM;
          else                    state_next = GAP;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_W'(1)) state_next = enable ? STREAM : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) state <= IDLE;
    else         state <= state_next;
  end

  // idx wraps to zero on its own after the last sample of a packet.
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      idx       <= '0;
      gap_cnt   <= '0;
      frame_cnt <= '0;
      error     <= 1'b0;
    end else begin
      if (xfer) idx <= idx + 1'b1;
      if (xfer && last)       gap_cnt <= gap;
      else if (state == GAP)  gap_cnt <= gap_cnt - 1'b1;
      if (xfer && last) frame_cnt <= frame_cnt + 1'b1;
      if (drop)         error <= 1'b1;
      else if (err_clr) error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fft_framer.sv
`timescale 1ns/1ps
// Bench for fft_framer at N=8, FIFO depth 4: vector table, hand-written corner sequences
// and randomized traffic against a queue-based packet model.
module tb_fft_framer;

  import fft_pkg::*;

  localparam int FFT_DEPTH  = 3;
  localparam int N          = 2**FFT_DEPTH;
  localparam int SINK_WIDTH = SINK_WIDTH_DEF;
  localparam int FIFO_DEPTH = 4;
  localparam int GAP_W      = 8;
  localparam int CNT_W      = 16;

  typedef struct {
    logic                  iv;
    logic                  rdy;
    logic                  clr;
    logic                  exp_ready;
    logic                  exp_valid;
    logic                  exp_sop;
    logic [SINK_WIDTH-1:0] exp_re;
    logic                  exp_err;
  } vec_t;

  logic             clk     = 1'b0;
  logic             aclr_n  = 1'b0;
  logic             enable  = 1'b0;
  logic             oneshot = 1'b0;
  logic [GAP_W-1:0] gap     = '0;
  logic             err_clr = 1'b0;
  logic             busy;
  logic [CNT_W-1:0] frame_cnt;
  logic             error;

  logic [SINK_WIDTH-1:0] seq;
  int n_compared   = 0;
  int n_mismatched = 0;
  vec_t vecs[$];

  fft_framer_if #(.SINK_WIDTH(SINK_WIDTH)) bus ();

  fft_framer #(
    .FFT_DEPTH  (FFT_DEPTH),
    .SINK_WIDTH (SINK_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH),
    .GAP_W      (GAP_W),
    .CNT_W      (CNT_W)
  ) dut (
    .clk       (clk),
    .aclr_n    (aclr_n),
    .enable    (enable),
    .oneshot   (oneshot),
    .gap       (gap),
    .err_clr   (err_clr),
    .bus       (bus),
    .busy      (busy),
    .frame_cnt (frame_cnt),
    .error     (error)
  );

  always #25 clk = ~clk;

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: actual %b required %b", name, act, exp);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_compared++;
    if (act !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input logic iv, input logic [SINK_WIDTH-1:0] re,
                                input logic [SINK_WIDTH-1:0] im, input logic rdy,
                                input logic clr);
    bus.in_valid     = iv;
    bus.in_Re        = re;
    bus.in_Im        = im;
    bus.source_ready = rdy;
    err_clr          = clr;
  endtask

  task automatic check_reset_values(input string tag);
    check_bit({tag, " source_valid"}, bus.source_valid, 1'b0);
    check_bit({tag, " source_sop"}, bus.source_sop, 1'b0);
    check_bit({tag, " source_eop"}, bus.source_eop, 1'b0);
    check_val({tag, " source_Re"}, 32'({bus.source_Re}), 32'd0);
    check_val({tag, " source_Im"}, 32'({bus.source_Im}), 32'd0);
    check_bit({tag, " busy"}, busy, 1'b0);
    check_val({tag, " frame_cnt"}, 32'(frame_cnt), 32'd0);
    check_bit({tag, " error"}, error, 1'b0);
    check_bit({tag, " in_ready"}, bus.in_ready, 1'b1);
  endtask

  // Leaves the bench at a falling edge with the DUT freshly out of reset and idle.
  task automatic do_reset();
    apply_stimulus(1'b0, '0, '0, 1'b1, 1'b0);
    enable  = 1'b0;
    oneshot = 1'b0;
    gap     = '0;
    aclr_n  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    aclr_n = 1'b1;
  endtask

  task automatic start_stream();
    do_reset();
    enable = 1'b1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add_vec(input int iv, input int rdy, input int clr, input int er,
                         input int ev, input int es, input int re, input int ee);
    vec_t v;
    v.iv        = (iv != 0);
    v.rdy       = (rdy != 0);
    v.clr       = (clr != 0);
    v.exp_ready = (er != 0);
    v.exp_valid = (ev != 0);
    v.exp_sop   = (es != 0);
    v.exp_re    = SINK_WIDTH'(re);
    v.exp_err   = (ee != 0);
    vecs.push_back(v);
  endtask

  // Packet-level reference: accepted samples in a queue, output position from the transfer
  // count, a bubble budget loaded from gap at each packet end, and a sticky drop flag.
  task automatic run_model(input string tag, input int cycles, input int mode);
    sample_t          q[$];
    sample_t          s;
    int               xfers;
    int               blocked;
    logic             err_m;
    logic             exp_valid;
    logic             iv, rdy, clr, wr_ok, last;
    logic [GAP_W-1:0] g;
    logic [31:0]      r;
    xfers   = 0;
    blocked = 0;
    err_m   = 1'b0;
    start_stream();
    for (int c = 0; c < cycles; c++) begin
      exp_valid = (blocked == 0) && (q.size() > 0);
      check_bit({tag, " in_ready"}, bus.in_ready, q.size() < FIFO_DEPTH);
      check_bit({tag, " source_valid"}, bus.source_valid, exp_valid);
      check_bit({tag, " source_sop"}, bus.source_sop, exp_valid && (xfers % N == 0));
      check_bit({tag, " source_eop"}, bus.source_eop, exp_valid && (xfers % N == N-1));
      if (exp_valid) begin
        check_val({tag, " source_Re"}, 32'({bus.source_Re}), 32'({q[0].Re}));
        check_val({tag, " source_Im"}, 32'({bus.source_Im}), 32'({q[0].Im}));
      end
      check_val({tag, " frame_cnt"}, 32'(frame_cnt), 32'(xfers / N));
      check_bit({tag, " error"}, error, err_m);
      check_bit({tag, " busy"}, busy, 1'b1);

      iv  = 1'b1;
      rdy = 1'b1;
      clr = 1'b0;
      g   = '0;
      s.Re = seq;
      s.Im = ~seq;
      seq  = seq + 1'b1;
      case (mode)
        1: g = GAP_W'(3);
        2: iv = (c % 2 == 0);
        3: begin
          iv  = ($urandom_range(0, 3) != 0);
          rdy = ($urandom_range(0, 3) != 0);
          clr = ($urandom_range(0, 9) == 0);
          g   = GAP_W'($urandom_range(0, 3));
          r   = $urandom;
          s.Re = r[13:0];
          s.Im = r[27:14];
        end
        default: ;
      endcase
      gap = g;
      apply_stimulus(iv, s.Re, s.Im, rdy, clr);

      @(posedge clk);
      wr_ok = iv && (q.size() < FIFO_DEPTH);
      last  = (xfers % N == N-1);
      if (exp_valid && rdy) begin
        void'(q.pop_front());
        xfers++;
      end
      if (exp_valid && rdy && last) blocked = int'(g);
      else if (blocked > 0)         blocked--;
      if (wr_ok) q.push_back(s);
      if (iv && !wr_ok) err_m = 1'b1;
      else if (clr)     err_m = 1'b0;
      @(negedge clk);
    end
    apply_stimulus(1'b0, '0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    #1ms;
    $display("[TB] FAIL watchdog: actual timeout required finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   xfers;
    logic done, saw_eop, found;
    logic [SINK_WIDTH-1:0] eop_re;

    seq = '0;
    apply_stimulus(1'b0, '0, '0, 1'b1, 1'b0);
    #10;
    check_reset_values("por");

    // Backpressure, overflow, sticky error, same-cycle drop with clear.
    add_vec(1,0,0, 1,1,1,0,0);
    add_vec(1,0,0, 1,1,1,0,0);
    add_vec(1,0,0, 1,1,1,0,0);
    add_vec(1,0,0, 0,1,1,0,0);
    add_vec(1,0,0, 0,1,1,0,1);
    add_vec(1,0,0, 0,1,1,0,1);
    add_vec(0,1,0, 1,1,0,1,1);
    add_vec(0,0,1, 1,1,0,1,0);
    add_vec(1,1,0, 1,1,0,2,0);
    add_vec(0,1,0, 1,1,0,3,0);
    add_vec(0,1,0, 1,1,0,6,0);
    add_vec(0,1,0, 1,0,0,0,0);
    add_vec(1,0,0, 1,1,0,7,0);
    add_vec(1,0,0, 1,1,0,7,0);
    add_vec(1,0,0, 1,1,0,7,0);
    add_vec(1,0,0, 0,1,0,7,0);
    add_vec(1,0,1, 0,1,0,7,1);
    add_vec(0,0,1, 0,1,0,7,0);
    do_reset();
    enable = 1'b1;
    seq    = '0;
    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].iv, seq, ~seq, vecs[i].rdy, vecs[i].clr);
      if (vecs[i].iv) seq = seq + 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_bit($sformatf("vec%0d in_ready", i), bus.in_ready, vecs[i].exp_ready);
      check_bit($sformatf("vec%0d valid", i), bus.source_valid, vecs[i].exp_valid);
      check_bit($sformatf("vec%0d sop", i), bus.source_sop, vecs[i].exp_sop);
      check_bit($sformatf("vec%0d error", i), error, vecs[i].exp_err);
      if (vecs[i].exp_valid)
        check_val($sformatf("vec%0d Re", i), 32'({bus.source_Re}), 32'({vecs[i].exp_re}));
    end

    seq = '0;
    run_model("continuous", 40, 0);
    seq = '0;
    run_model("gap3", 60, 1);
    seq = '0;
    run_model("underrun", 48, 2);
    run_model("random", 400, 3);

    // One-shot: one packet, then idle.
    do_reset();
    enable  = 1'b1;
    oneshot = 1'b1;
    seq     = '0;
    xfers   = 0;
    done    = 1'b0;
    eop_re  = '0;
    for (int c = 0; c < 40 && !done; c++) begin
      apply_stimulus(1'b1, seq, ~seq, 1'b1, 1'b0);
      seq = seq + 1'b1;
      saw_eop = bus.source_valid && bus.source_eop;
      if (saw_eop) eop_re = bus.source_Re;
      if (bus.source_valid) xfers++;
      @(posedge clk);
      @(negedge clk);
      if (saw_eop) begin
        done = 1'b1;
        check_bit("oneshot busy after eop", busy, 1'b0);
        check_val("oneshot frame_cnt", 32'(frame_cnt), 32'd1);
        check_val("oneshot eop Re", 32'(eop_re), 32'd7);
      end
    end
    check_bit("oneshot eop seen", done, 1'b1);
    enable = 1'b0;
    for (int c = 0; c < 6; c++) begin
      apply_stimulus(1'b1, seq, ~seq, 1'b1, 1'b0);
      if (bus.source_valid) xfers++;
      @(posedge clk);
      @(negedge clk);
    end
    check_val("oneshot transfers", 32'(xfers), 32'd8);

    // Enable dropped at idx 3: packet still completes, then idle.
    do_reset();
    enable = 1'b1;
    seq    = '0;
    xfers  = 0;
    done   = 1'b0;
    eop_re = '0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (bus.source_valid && {bus.source_Re} == 14'd3) enable = 1'b0;
      apply_stimulus(1'b1, seq, ~seq, 1'b1, 1'b0);
      seq = seq + 1'b1;
      saw_eop = bus.source_valid && bus.source_eop;
      if (saw_eop) eop_re = bus.source_Re;
      if (bus.source_valid) xfers++;
      @(posedge clk);
      @(negedge clk);
      if (saw_eop) begin
        done = 1'b1;
        check_bit("enable_drop busy after eop", busy, 1'b0);
        check_val("enable_drop frame_cnt", 32'(frame_cnt), 32'd1);
        check_val("enable_drop eop Re", 32'(eop_re), 32'd7);
      end
    end
    check_bit("enable_drop eop seen", done, 1'b1);
    for (int c = 0; c < 6; c++) begin
      apply_stimulus(1'b1, seq, ~seq, 1'b1, 1'b0);
      if (bus.source_valid) xfers++;
      @(posedge clk);
      @(negedge clk);
    end
    check_val("enable_drop transfers", 32'(xfers), 32'd8);

    // Asynchronous reset in the middle of the second packet.
    do_reset();
    enable = 1'b1;
    seq    = '0;
    found  = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (bus.source_valid && {bus.source_Re} == 14'd13) begin
        found = 1'b1;
        check_val("midreset frame_cnt before", 32'(frame_cnt), 32'd1);
        aclr_n = 1'b0;
        #1;
        check_reset_values("midreset");
      end else begin
        apply_stimulus(1'b1, seq, ~seq, 1'b1, 1'b0);
        seq = seq + 1'b1;
        @(posedge clk);
        @(negedge clk);
      end
    end
    check_bit("midreset idx5 reached", found, 1'b1);
    @(negedge clk);
    aclr_n = 1'b1;
    seq    = 14'd100;
    found  = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      apply_stimulus(1'b1, seq, ~seq, 1'b1, 1'b0);
      seq = seq + 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (bus.source_valid) begin
        found = 1'b1;
        check_bit("after reset sop", bus.source_sop, 1'b1);
        check_val("after reset frame_cnt", 32'(frame_cnt), 32'd0);
        check_val("after reset Re", 32'({bus.source_Re}), 32'd100);
      end
    end
    check_bit("after reset output seen", found, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/fft_framer.md
Name: fft_framer

Overview:
- Synthesizable front-end that packs a continuous complex sample stream into FFT input packets of 2**FFT_DEPTH samples, with sop/eop/valid framing for fft_int's sink.
- Replaces hand-made framing in benches and upstream logic. Adds an input FIFO, backpressure from the FFT, one-shot/continuous modes, programmable inter-frame gap, a frame counter and sticky overflow detection.

Parameters:
- FFT_DEPTH, 11: packet length N = 2**FFT_DEPTH.
- SINK_WIDTH, 14: sample width, Re and Im each, signed.
- FIFO_DEPTH, 16: input FIFO entries; must be a power of 2 and at least 2.
- GAP_W, 8: width of the gap input.
- CNT_W, 16: width of frame_cnt.

Ports:
- clk  in  1  processing clock.
- aclr_n  in  1  asynchronous active-low reset.
- enable  in  1  high: framing allowed.
- oneshot  in  1  high: return to IDLE after the current frame.
- gap  in  GAP_W  idle cycles between frames; sampled at each eop transfer.
- err_clr  in  1  clears error.
- in_valid  in  1  input sample valid.
- in_Re  in  SINK_WIDTH  signed real part of input.
- in_Im  in  SINK_WIDTH  signed imaginary part of input.
- in_ready  out  1  high when the FIFO is not full.
- source_ready  in  1  FFT sink can accept.
- source_valid  out  1  output sample valid.
- source_sop  out  1  first sample of packet; qualified by source_valid.
- source_eop  out  1  last sample of packet; qualified by source_valid.
- source_Re  out  SINK_WIDTH  output real part.
- source_Im  out  SINK_WIDTH  output imaginary part.
- busy  out  1  high when the state is not IDLE.
- frame_cnt  out  CNT_W  completed frames; wraps at 2**CNT_W.
- error  out  1  sticky overflow flag.

Behaviour:
- Reset (aclr_n low, asynchronous):
  - FIFO empty, state IDLE, idx 0, gap counter 0.
  - Outputs: frame_cnt 0, error 0, busy 0, source_valid/sop/eop 0, source_Re/Im 0, in_ready 1.
- Write: occurs when in_valid and not full at the clock edge.
  - in_valid while full: sample dropped, error set next cycle.
  - A write is dropped even if a read happens in the same cycle.
- FIFO: first-word-fall-through with a registered head. A sample written in cycle t is visible on source_* at t+1 at the earliest.
- Transfer: source_valid and source_ready. Data, sop and eop are held stable while source_valid is high and source_ready is low.
- idx counts 0..N-1 within a packet.
  - source_sop = (idx==0).
  - source_eop = (idx==N-1).
- IDLE:
  - source_valid 0.
  - Go to STREAM with idx 0 when enable is high.
  - The FIFO keeps accepting input while IDLE.
- STREAM:
  - source_valid = FIFO not empty. Underrun simply stalls; it is not an error.
  - Each transfer increments idx.
  - On the eop transfer: frame_cnt++ and idx resets to 0. Next state:
    - oneshot high or enable low: IDLE.
    - gap == 0: STREAM; back-to-back frames with no bubble.
    - otherwise: GAP, with the counter loaded to gap.
- GAP:
  - source_valid 0; the counter decrements each cycle.
  - When the counter reaches 1: go to STREAM if enable is high, else IDLE.
- enable low mid-frame: the frame completes (all N samples), then IDLE. Partial packets are never emitted.
- error:
  - Set by a dropped write; cleared by err_clr.
  - A dropped write and err_clr in the same cycle leave error = 1.
- busy = state != IDLE.
- Widths: samples pass through unmodified. idx is FFT_DEPTH bits and wraps naturally at N.

Decomposition:
- Package fft_pkg:
  - typedef for the state enum (IDLE, STREAM, GAP).
  - typedef sample_t as a struct {signed Re, Im} of SINK_WIDTH.
  - localparam function computing FFT_WIDTH = SINK_WIDTH + (FFT_DEPTH+1)/2 for downstream use.
- Sub-module fft_framer_fifo: synchronous FWFT FIFO.
  - Parameters: width, depth.
  - Ports: full, empty, wr, rd, din, dout.
- Framer FSM, counters and error logic stay in fft_framer.

Test Plan (FFT_DEPTH=3, N=8; FIFO_DEPTH=4; clk 50 ns):
- Continuous:
  - Stimulus: enable=1, oneshot=0, gap=0, in_valid=1 every cycle, Re=0,1,2,..., source_ready=1.
  - Response: sop on Re=0,8,16; eop on Re=7,15; frame_cnt increments by 1 per 8 transfers; error 0.
- Gap:
  - Stimulus: gap=3, otherwise as above.
  - Response: exactly 3 cycles of source_valid=0 between eop (Re=7) and the next sop (Re=8, when no drops occur).
- Backpressure/overflow:
  - Stimulus: source_ready=0 for 6 cycles while in_valid=1.
  - Response: in_ready falls after 4 writes; 2 samples dropped; error=1 sticky; outputs held stable; err_clr → error 0.
- One-shot and enable mid-frame:
  - Stimulus (a): oneshot=1.
  - Response (a): exactly 8 transfers, then busy=0, frame_cnt=1.
  - Stimulus (b): enable dropped at idx=3.
  - Response (b): frame completes through eop, then IDLE.
- Reset mid-frame:
  - Stimulus: assert aclr_n=0 at idx=5, then release.
  - Response: all outputs at reset values immediately (asynchronously); after release with enable=1, the next output has sop=1 and frame_cnt=0.
- Underrun:
  - Stimulus: in_valid toggling 1/0.
  - Response: source_valid toggles; idx advances only on transfers; the packet is still 8 samples with correct sop/eop.
